cpu_controller: RTL
===================

Name: cpu_controller

Overview:
- Instruction register plus Moore control FSM that drives the 16-bit datapath.
- Latches one instruction, then sequences register-file reads and writes, the A/B/C/status loads, the mux selects and ALUop to execute it.
- Raises w when idle.
- Sits between the instruction source/testbench and the datapath in the top-level cpu.

Parameters:
- None. ISA field widths and encodings are fixed in cpu_pkg.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- in  in  16  instruction word to latch
- load  in  1  IR load strobe; honoured only while w=1
- s  in  1  start strobe; honoured only while w=1
- w  out  1  idle/ready (state WAIT)
- readnum  out  3  register-file read address
- writenum  out  3  register-file write address (same value as readnum)
- write  out  1  register-file write enable
- loada  out  1  A register load
- loadb  out  1  B register load
- loadc  out  1  C register load
- loads  out  1  status (N,V,Z) load
- asel  out  1  1 = Ain is zero, 0 = Ain is A
- bsel  out  1  1 = Bin is sximm5, 0 = Bin is shifted B; always 0 in this block
- vsel  out  2  write-back select: 00 mdata, 01 sximm8, 10 PC, 11 datapath_out
- ALUop  out  2  00 add, 01 sub, 10 and, 11 not-B
- shift  out  2  shifter control
- sximm5  out  16  sign-extended IR[4:0]
- sximm8  out  16  sign-extended IR[7:0]

Behaviour:
- Encoding: IR[15:13] opcode, [12:11] op, [10:8] Rn, [7:5] Rd, [4:3] sh, [2:0] Rm, [7:0] imm8.
- Supported instructions:
  - 110/10 MOV Rn,#imm8
  - 110/00 MOV Rd,Rm{,sh}
  - 101/00 ADD
  - 101/01 CMP
  - 101/10 AND
  - 101/11 MVN
- IR:
  - 16-bit register, cleared to 0 on reset.
  - Loaded from in on the clk edge where load=1 and state=WAIT.
  - load in any other state is ignored, so IR is stable for the whole instruction.
- All outputs are combinational from state and IR (Moore). Every strobe is 0 outside the states listed below.
- States and transitions:
  - WAIT: w=1. Goes to DECODE if s=1, otherwise stays.
  - DECODE: no strobes.
    - MOV imm goes to WR_IMM.
    - MOV reg and MVN go to GET_B.
    - ADD, CMP and AND go to GET_A.
    - Any other opcode/op goes to WAIT with no side effects.
  - WR_IMM: readnum=writenum=Rn, vsel=01, write=1. Next WAIT.
  - GET_A: readnum=Rn, loada=1. Next GET_B.
  - GET_B: readnum=Rm, loadb=1. Next CMP for CMP, otherwise EXEC.
  - EXEC: bsel=0, shift=sh, loadc=1. Next WR_RD.
    - MOV reg: asel=1, ALUop=00 (result = 0 + shifted Rm).
    - ADD/AND/MVN: asel=0, ALUop=IR[12:11].
  - CMP: asel=0, bsel=0, ALUop=01, shift=sh, loads=1, loadc=0. Next WAIT.
  - WR_RD: readnum=writenum=Rd, vsel=11, write=1. Next WAIT.
- shift = sh only in EXEC and CMP, 00 elsewhere. readnum/writenum = Rn when not otherwise specified.
- Latency, counted as rising edges with w=0:
  - MOV imm: 2
  - MOV reg, MVN, CMP: 4
  - ADD, AND: 5
  - unsupported: 1
- s held high across an instruction starts the next instruction immediately on return to WAIT. This is legal and uses the current IR.
- Reset assertion at any time, including mid-instruction: state=WAIT and IR=0 immediately (asynchronous), all strobes deasserted combinationally, w=1. Deassertion takes effect on the next clk edge.
- sximm5/sximm8 are pure sign extension of the current IR in every state.

Decomposition:
- cpu_pkg holds:
  - opcode/op constants
  - state encoding (WAIT, DECODE, WR_IMM, GET_A, GET_B, EXEC, CMP, WR_RD)
  - vsel codes
  - ALUop codes
- Sub-module instr_decoder: combinational. IR → opcode, op, ALUop, sh, Rn/Rd/Rm, sximm5, sximm8. It also does the register-select mux (Rn/Rd/Rm) driving readnum/writenum.
- FSM and IR live in cpu_controller.

Test Plan:
- MOV R0,#7:
  - Stimulus: in=16'hD007, load pulse, s pulse.
  - Response: after the DECODE edge, write=1, writenum=0, vsel=01, sximm8=16'h0007; w=1 after 2 edges.
- MOV R1,#-2:
  - Stimulus: in=16'hD1FE.
  - Response: sximm8=16'hFFFE, writenum=1.
- ADD R2,R1,R0,LSL#1:
  - Stimulus: in=16'hA148.
  - Response: GET_A (readnum=1, loada); GET_B (readnum=0, loadb); EXEC (asel=0, bsel=0, ALUop=00, shift=01, loadc); WR_RD (writenum=2, vsel=11, write). w=0 for exactly 5 edges.
- CMP R1,R0:
  - Stimulus: in=16'hA900.
  - Response: loads=1 for one cycle with ALUop=01; write and loadc never asserted; w=0 for 4 edges.
- MVN R3,R0:
  - Stimulus: in=16'hB860.
  - Response: loada never asserted; EXEC ALUop=11; WR_RD writenum=3.
- Error and reset handling:
  - in=16'h0000 + s: DECODE then WAIT, no strobes.
  - load with in=16'hD0FF while in GET_B: IR unchanged.
  - reset_n=0 in GET_B: w=1 and loadb=0 immediately, IR=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - ISA encodings, FSM states and select codes for the cpu controller
package cpu_pkg;

    // Opcode field IR[15:13]
    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    // op field IR[12:11]
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    // Write-back select
    localparam logic [1:0] VSEL_MDATA = 2'b00;
    localparam logic [1:0] VSEL_IMM8  = 2'b01;
    localparam logic [1:0] VSEL_PC    = 2'b10;
    localparam logic [1:0] VSEL_DP    = 2'b11;

    // ALU operations
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_NOT = 2'b11;

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_DECODE,
        ST_WR_IMM,
        ST_GET_A,
        ST_GET_B,
        ST_EXEC,
        ST_CMP,
        ST_WR_RD
    } state_t;

    // Which IR register field drives readnum/writenum
    typedef enum logic [1:0] {
        SEL_RN,
        SEL_RD,
        SEL_RM
    } regsel_t;

endpackage

// File: rtl/cpu_controller_if.sv
// rtl/cpu_controller_if.sv - instruction source / datapath control bundle
interface cpu_controller_if;
    logic [15:0] in;
    logic        load;
    logic        s;
    logic        w;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [1:0]  vsel;
    logic [1:0]  ALUop;
    logic [1:0]  shift;
    logic [15:0] sximm5;
    logic [15:0] sximm8;

    // Instruction source / top-level side
    modport master (
        output in, load, s,
        input  w, readnum, writenum, write, loada, loadb, loadc, loads,
               asel, bsel, vsel, ALUop, shift, sximm5, sximm8
    );

    // Controller side
    modport slave (
        input  in, load, s,
        output w, readnum, writenum, write, loada, loadb, loadc, loads,
               asel, bsel, vsel, ALUop, shift, sximm5, sximm8
    );
endinterface

// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - IR field extraction, sign extension and register-select mux
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [15:0] ir,
    input  regsel_t     nsel,
    output logic [2:0]  opcode,
    output logic [1:0]  op,
    output logic [1:0]  sh,
    output logic [2:0]  regnum,
    output logic [15:0] sximm5,
    output logic [15:0] sximm8
);

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign sh     = ir[4:3];
    assign sximm5 = {{11{ir[4]}}, ir[4:0]};
    assign sximm8 = {{8{ir[7]}}, ir[7:0]};

    // Pick Rn, Rd or Rm as the register-file address
    always_comb begin
        regnum = ir[10:8];
        case (nsel)
            SEL_RD:  regnum = ir[7:5];
            SEL_RM:  regnum = ir[2:0];
            default: regnum = ir[10:8];
        endcase
    end

endmodule

// File: rtl/cpu_controller.sv
// rtl/cpu_controller.sv - instruction register and Moore control FSM for the 16-bit datapath
module cpu_controller
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    cpu_controller_if.slave   bus
);

    logic [15:0] ir;
    state_t      state;
    state_t      state_next;
    regsel_t     nsel;
    logic [2:0]  opcode;
    logic [1:0]  op;
    logic [1:0]  sh;
    logic [2:0]  regnum;
    logic        is_mov_reg;

    instr_decoder u_decoder (
        .ir     (ir),
        .nsel   (nsel),
        .opcode (opcode),
        .op     (op),
        .sh     (sh),
        .regnum (regnum),
        .sximm5 (bus.sximm5),
        .sximm8 (bus.sximm8)
    );

    assign bus.readnum  = regnum;
    assign bus.writenum = regnum;
    assign is_mov_reg   = (opcode == OPC_MOV) && (op == OP_MOV_REG);

    // IR only accepts a new word while idle, so it is stable across an instruction
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir <= '0;
        end else if (bus.load && (state == ST_WAIT)) begin
            ir <= bus.in;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_WAIT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_WAIT:   state_next = bus.s ? ST_DECODE : ST_WAIT;
            ST_DECODE: begin
                case ({opcode, op})
                    {OPC_MOV, OP_MOV_IMM}: state_next = ST_WR_IMM;
                    {OPC_MOV, OP_MOV_REG},
                    {OPC_ALU, OP_MVN}:     state_next = ST_GET_B;
                    {OPC_ALU, OP_ADD},
                    {OPC_ALU, OP_CMP},
                    {OPC_ALU, OP_AND}:     state_next = ST_GET_A;
                    default:               state_next = ST_WAIT;
                endcase
            end
            ST_WR_IMM: state_next = ST_WAIT;
            ST_GET_A:  state_next = ST_GET_B;
            ST_GET_B:  state_next = ((opcode == OPC_ALU) && (op == OP_CMP)) ? ST_CMP : ST_EXEC;
            ST_EXEC:   state_next = ST_WR_RD;
            ST_CMP:    state_next = ST_WAIT;
            ST_WR_RD:  state_next = ST_WAIT;
            default:   state_next = ST_WAIT;
        endcase
    end

    // Moore outputs: every strobe idles at 0, register select defaults to Rn
    always_comb begin
        bus.w     = 1'b0;
        nsel      = SEL_RN;
        bus.write = 1'b0;
        bus.loada = 1'b0;
        bus.loadb = 1'b0;
        bus.loadc = 1'b0;
        bus.loads = 1'b0;
        bus.asel  = 1'b0;
        bus.bsel  = 1'b0;
        bus.vsel  = VSEL_MDATA;
        bus.ALUop = ALU_ADD;
        bus.shift = 2'b00;
        case (state)
            ST_WAIT:   bus.w = 1'b1;
            ST_WR_IMM: begin
                bus.vsel  = VSEL_IMM8;
                bus.write = 1'b1;
            end
            ST_GET_A:  bus.loada = 1'b1;
            ST_GET_B: begin
                nsel      = SEL_RM;
                bus.loadb = 1'b1;
            end
            ST_EXEC: begin
                // MOV reg computes 0 + shifted Rm through the ALU
                bus.asel  = is_mov_reg;
                bus.ALUop = is_mov_reg ? ALU_ADD : op;
                bus.shift = sh;
                bus.loadc = 1'b1;
            end
            ST_CMP: begin
                bus.ALUop = ALU_SUB;
                bus.shift = sh;
                bus.loads = 1'b1;
            end
            ST_WR_RD: begin
                nsel      = SEL_RD;
                bus.vsel  = VSEL_DP;
                bus.write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
